shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Multi-cycle controller that performs variable 32-bit shifts (SLL/SRL/SRA, shamt 0..31)
//  by repeatedly applying a fixed shift-by-2 / shift-by-1 step datapath to a working register.
//  Sits beside the ALU in the CPU datapath; the decoder issues start_i, and the result is
//  written back once done_o pulses. Replaces a full barrel shifter with an area-cheap iterative unit.
// PARAMETERS
//  DATA_W   32  datapath width
//  SHAMT_W  5   shift-amount width (max shift = 2**SHAMT_W-1)
// PORTS
//  clk_i     in   1        clock, all flops rising-edge
//  rst_i     in   1        asynchronous reset, active-low
//  start_i   in   1        request; sampled only when ready_o=1
//  op_i      in   2        00 SLL, 01 SRL, 10 SRA, 11 reserved
//  data_i    in   DATA_W   operand, sampled with start_i
//  shamt_i   in   SHAMT_W  shift amount, sampled with start_i
//  ready_o   out  1        can accept start (state IDLE or DONE)
//  busy_o    out  1        state RUN
//  done_o    out  1        one-cycle completion pulse
//  result_o  out  DATA_W   shifted result; valid while done_o=1, held until next accepted start
//  err_o     out  1        pulses with done_o when op_i was 11
// BEHAVIOUR
//  - Reset (rst_i=0, async): state IDLE, rem=0, work reg=0, result_o=0, done_o=0, err_o=0,
//    busy_o=0; ready_o=1 but start_i ignored while rst_i=0. Reset mid-RUN aborts, no done_o.
//  - FSM: IDLE, RUN, DONE. ready_o=(state!=RUN); busy_o=(state==RUN); done_o=(state==DONE).
//  - Accept (edge E0, ready_o=1 & start_i=1): latch op, data into work reg, shamt into rem.
//    shamt==0 or op==11 -> DONE (result=data_i unchanged; err_o=1 if op==11); else -> RUN.
//  - RUN, each edge: rem>=2 -> work shifted by 2, rem-=2; rem==1 -> shift by 1, rem=0.
//    Transition to DONE on the edge where rem reaches 0.
//  - Fill: SLL zeros into LSBs; SRL zeros into MSBs; SRA replicates work[DATA_W-1] each step.
//  - Latency: done_o high in the cycle after edge E0+ceil(shamt/2); exactly one cycle wide.
//  - DONE -> IDLE next edge unless start_i accepted (back-to-back allowed: new op latched,
//    done_o still high in that DONE cycle for the previous op).
//  - start_i while RUN ignored (no queueing); op/data/shamt inputs don't-care outside accept.
//  - result_o and err_o registered; err_o cleared on next accepted start.
// STRUCTURE
//  - Package shift_seq_pkg: op encodings (OP_SLL/OP_SRL/OP_SRA/OP_RSV), FSM state enum
//    (S_IDLE/S_RUN/S_DONE), DATA_W/SHAMT_W defaults.
//  - Sub-module shift_step: combinational, inputs work, op, two_i (1=shift 2, 0=shift 1);
//    output next work. Controller holds FSM, rem counter, work/result regs.
// TESTING
//  1. SLL data=0x0000_0003 shamt=5 -> done_o after E0+3, result 0x0000_0060, err_o=0.
//  2. SRA data=0x8000_0000 shamt=31 -> done_o after E0+16, result 0xFFFF_FFFF;
//     SRL same data/shamt -> 0x0000_0001.
//  3. SRL data=0xF000_0000 shamt=0 -> done_o in cycle after E0, result 0xF000_0000;
//     op=11 data=0x1234_5678 -> same timing, result 0x1234_5678, err_o=1.
//  4. Start SLL shamt=10, pulse start_i (SRL, other data) at RUN cycle 2 -> ignored,
//     result 0x0000_0C00 for data=0x3; done_o after E0+5.
//  5. Back-to-back: second start in DONE cycle -> both done_o pulses, results correct,
//     no IDLE cycle between.
//  6. Drop rst_i mid-RUN (shamt=20, after 4 steps) -> immediate IDLE, result_o=0, no done_o;
//     release, new SLL 0x1 by 31 -> 0x8000_0000 after E0+16.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings and default widths for the iterative shift controller.
// Latency and backpressure: not applicable, this file holds declarations only.
package shift_seq_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_RSV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/completion bundle between the decoder (master) and the shift controller (slave).
// Latency and backpressure: set by the slave; a request is taken only while ready_o is high.
interface shift_seq_ctrl_if #(
   parameter int DATA_W  = shift_seq_pkg::DATA_W,
   parameter int SHAMT_W = shift_seq_pkg::SHAMT_W
);
   logic               start_i;
   logic [1:0]         op_i;
   logic [DATA_W-1:0]  data_i;
   logic [SHAMT_W-1:0] shamt_i;
   logic               ready_o;
   logic               busy_o;
   logic               done_o;
   logic [DATA_W-1:0]  result_o;
   logic               err_o;

   modport master (
      output start_i, op_i, data_i, shamt_i,
      input  ready_o, busy_o, done_o, result_o, err_o
   );

   modport slave (
      input  start_i, op_i, data_i, shamt_i,
      output ready_o, busy_o, done_o, result_o, err_o
   );
endinterface

// File: rtl/shift_seq_ctrl_step.sv
// One iteration of the shifter: moves work by 2 or 1 bit in the direction given by op.
// Latency: combinational; backpressure: none.
module shift_step
   import shift_seq_pkg::*;
#(
   parameter int DATA_W = shift_seq_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] work,
   input  op_e               op,
   input  logic              two_i,
   output logic [DATA_W-1:0] work_nxt
);

   always_comb begin
      work_nxt = work;
      case (op)
         OP_SLL: work_nxt = two_i ? {work[DATA_W-3:0], 2'b00}
                                  : {work[DATA_W-2:0], 1'b0};
         OP_SRL: work_nxt = two_i ? {2'b00, work[DATA_W-1:2]}
                                  : {1'b0, work[DATA_W-1:1]};
         // sign bit is taken from the current work value so each step replicates it
         OP_SRA: work_nxt = two_i ? {{2{work[DATA_W-1]}}, work[DATA_W-1:2]}
                                  : {work[DATA_W-1], work[DATA_W-1:1]};
         default: work_nxt = work;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Iterative SLL/SRL/SRA unit: done_o pulses ceil(shamt/2) edges after accept (0 for shamt 0 / reserved op).
// Backpressure: ready_o low while running; a start seen then is dropped, not queued.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int DATA_W  = shift_seq_pkg::DATA_W,
   parameter int SHAMT_W = shift_seq_pkg::SHAMT_W
) (
   input  logic          clk_i,
   input  logic          rst_i,
   shift_seq_ctrl_if.slave bus
);

   state_e             state_q, state_d;
   op_e                op_q;
   op_e                op_in;
   logic [SHAMT_W-1:0] rem_q;
   logic [SHAMT_W-1:0] rem_nxt;
   logic [DATA_W-1:0]  work_q;
   logic [DATA_W-1:0]  work_nxt;
   logic [DATA_W-1:0]  result_q;
   logic               err_q;
   logic               ready;
   logic               accept;
   logic               immediate;
   logic               two;

   assign op_in     = op_e'(bus.op_i);
   assign ready     = (state_q != S_RUN);
   assign accept    = ready && bus.start_i;
   assign immediate = (bus.shamt_i == '0) || (op_in == OP_RSV);
   assign two       = (rem_q > SHAMT_W'(1));
   assign rem_nxt   = two ? (rem_q - SHAMT_W'(2)) : (rem_q - SHAMT_W'(1));

   shift_step #(.DATA_W(DATA_W)) u_step (
      .work     (work_q),
      .op       (op_q),
      .two_i    (two),
      .work_nxt (work_nxt)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d = immediate ? S_DONE : S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (rem_nxt == '0) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // err_q is rewritten every edge so it is high only in the DONE cycle of a reserved op
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         op_q     <= OP_SLL;
         rem_q    <= '0;
         work_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (accept) begin
            op_q   <= op_in;
            work_q <= bus.data_i;
            rem_q  <= bus.shamt_i;
            err_q  <= (op_in == OP_RSV);
            if (immediate) begin
               result_q <= bus.data_i;
            end
         end else if (state_q == S_RUN) begin
            work_q <= work_nxt;
            rem_q  <= rem_nxt;
            if (rem_nxt == '0) begin
               result_q <= work_nxt;
            end
         end
      end
   end

   assign bus.ready_o  = ready;
   assign bus.busy_o   = (state_q == S_RUN);
   assign bus.done_o   = (state_q == S_DONE);
   assign bus.result_o = result_q;
   assign bus.err_o    = err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed scoreboard bench for shift_seq_ctrl: stimulus pushes expected result/err/done cycle,
// a negedge monitor pops and compares on every done_o pulse.
module tb_shift_seq_ctrl;
   import shift_seq_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;

   shift_seq_ctrl_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

   shift_seq_ctrl #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] res;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // monitor: every done_o pulse must match the oldest outstanding request
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_i && bus.done_o) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no completion", cyc);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_result"}, bus.result_o, e.res);
            chk({e.name, "_err"}, {31'd0, bus.err_o}, {31'd0, e.err});
            chk({e.name, "_done_cycle"}, cyc, e.cyc);
         end
      end
   end

   task automatic issue(input string name, input logic [1:0] op, input logic [31:0] data,
                        input logic [4:0] shamt, input logic [31:0] exp_res,
                        input logic exp_err, input int lat, input bit push);
      int n = 0;
      exp_t e;
      @(negedge clk_i);
      while (!bus.ready_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (!bus.ready_o) begin
         checks++;
         errors++;
         $display("FAIL %s_ready_timeout: got ready_o=0 expected 1 within 100 cycles", name);
      end
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.data_i  = data;
      bus.shamt_i = shamt;
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      bus.op_i    = 2'b01;
      bus.data_i  = 32'hA5A5_A5A5;
      bus.shamt_i = 5'd3;
      if (push) begin
         e.res  = exp_res;
         e.err  = exp_err;
         e.cyc  = cyc + lat;
         e.name = name;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
      $fatal(1, "timeout");
   end

   initial begin
      bus.start_i = 1'b1;
      bus.op_i    = 2'b00;
      bus.data_i  = 32'h0000_00FF;
      bus.shamt_i = 5'd4;
      repeat (3) @(negedge clk_i);
      chk("rst_ready",  {31'd0, bus.ready_o}, 32'd1);
      chk("rst_busy",   {31'd0, bus.busy_o},  32'd0);
      chk("rst_done",   {31'd0, bus.done_o},  32'd0);
      chk("rst_result", bus.result_o,         32'd0);
      chk("rst_err",    {31'd0, bus.err_o},   32'd0);
      bus.start_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("post_rst_busy", {31'd0, bus.busy_o}, 32'd0);

      // basic shifts
      issue("sll3_5",    OP_SLL, 32'h0000_0003, 5'd5,  32'h0000_0060, 1'b0, 3,  1'b1); drain();
      issue("sra_m_31",  OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 16, 1'b1); drain();
      issue("srl_m_31",  OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 16, 1'b1); drain();
      issue("sra_pos_3", OP_SRA, 32'h4000_0000, 5'd3,  32'h0800_0000, 1'b0, 2,  1'b1); drain();
      issue("srl_ones1", OP_SRL, 32'hFFFF_FFFF, 5'd1,  32'h7FFF_FFFF, 1'b0, 1,  1'b1); drain();

      // zero shift and reserved op complete immediately
      issue("srl_sh0",   OP_SRL, 32'hF000_0000, 5'd0,  32'hF000_0000, 1'b0, 0,  1'b1); drain();
      issue("rsv_op",    OP_RSV, 32'h1234_5678, 5'd7,  32'h1234_5678, 1'b1, 0,  1'b1); drain();

      // start while running is dropped
      issue("sll_ign",   OP_SLL, 32'h0000_0003, 5'd10, 32'h0000_0C00, 1'b0, 5,  1'b1);
      @(negedge clk_i);
      chk("run_busy",  {31'd0, bus.busy_o},  32'd1);
      chk("run_ready", {31'd0, bus.ready_o}, 32'd0);
      bus.start_i = 1'b1;
      bus.op_i    = OP_SRL;
      bus.data_i  = 32'hFFFF_0000;
      bus.shamt_i = 5'd1;
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      drain();

      // back-to-back: second start lands in the first op's DONE cycle
      issue("b2b_first",  OP_SLL, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 1, 1'b1);
      issue("b2b_second", OP_SRA, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 2, 1'b1);
      drain();

      // reset mid-run aborts with no completion
      issue("abort", OP_SLL, 32'h0001_2345, 5'd20, 32'd0, 1'b0, 10, 1'b0);
      repeat (4) @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      #1;
      chk("abort_ready",  {31'd0, bus.ready_o}, 32'd1);
      chk("abort_busy",   {31'd0, bus.busy_o},  32'd0);
      chk("abort_done",   {31'd0, bus.done_o},  32'd0);
      chk("abort_result", bus.result_o,         32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (12) @(negedge clk_i);
      issue("sll1_31", OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 16, 1'b1);
      drain();

      chk("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
